// File: rtl/fft_out_sequencer_if.sv
// Read-port and output-stream bundle of the FFT result drain sequencer.
// The master side issues RAM reads and sources the output stream.
interface fft_out_sequencer_if #(
   parameter int unsigned N_LOG2 = 8,
   parameter int unsigned DW     = 32
);
   logic              rd_en;
   logic [N_LOG2-1:0] rd_addr;
   logic [DW-1:0]     rd_data;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_last;
   logic              out_ready;

   modport master (
      output rd_en, rd_addr, out_valid, out_data, out_last,
      input  rd_data, out_ready
   );

   modport slave (
      input  rd_en, rd_addr, out_valid, out_data, out_last,
      output rd_data, out_ready
   );
endinterface

// File: rtl/fft_out_sequencer.sv
// Drains the FFT result RAM after a transform: issues reads in bit-reversed or natural
// order and streams frame_len words through a 2-entry FIFO with a last marker.
module fft_out_sequencer #(
   parameter int unsigned N_LOG2 = 8,
   parameter int unsigned DW     = 32,
   parameter bit          BITREV = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [N_LOG2:0]     frame_len,
   output logic                busy,
   output logic                done,
   fft_out_sequencer_if.master bus
);

   localparam logic [N_LOG2:0] MAX_LEN = {1'b1, {N_LOG2{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } entry_t;

   state_t            state;
   logic [N_LOG2-1:0] idx;
   logic [N_LOG2-1:0] last_idx;
   logic              pend;
   logic              pend_last;
   logic [1:0]        cnt;
   entry_t            head;
   entry_t            tail;

   logic              pop_c;
   logic              push_c;
   logic              rd_c;
   logic              final_rd_c;
   logic [1:0]        cnt_nxt_c;
   entry_t            wr_c;

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
      logic [N_LOG2-1:0] r;
      r = '0;
      for (int i = 0; i < int'(N_LOG2); i++) begin
         r[i] = v[int'(N_LOG2) - 1 - i];
      end
      return r;
   endfunction

   // A read is safe when the FIFO will hold at most one word after this edge:
   // the read's data lands one cycle later and always finds a free slot.
   always_comb begin
      pop_c      = bus.out_valid & bus.out_ready;
      push_c     = pend;
      cnt_nxt_c  = cnt + 2'(push_c) - 2'(pop_c);
      rd_c       = (state == RUN) && (cnt_nxt_c < 2'd2);
      final_rd_c = rd_c && (idx == last_idx);
      wr_c.last  = pend_last;
      wr_c.data  = bus.rd_data;
   end

   assign bus.rd_en    = rd_c;
   assign bus.rd_addr  = BITREV ? bitrev(idx) : idx;
   assign bus.out_data = head.data;
   assign bus.out_last = head.last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         last_idx      <= '0;
         pend          <= 1'b0;
         pend_last     <= 1'b0;
         cnt           <= 2'd0;
         head          <= '0;
         tail          <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         bus.out_valid <= 1'b0;
      end else begin
         done          <= 1'b0;
         pend          <= rd_c;
         pend_last     <= final_rd_c;
         cnt           <= cnt_nxt_c;
         bus.out_valid <= (cnt_nxt_c != 2'd0);

         // Head register is the output word; tail holds the second entry.
         case ({push_c, pop_c})
            2'b10: begin
               if (cnt == 2'd0) head <= wr_c;
               else             tail <= wr_c;
            end
            2'b01: begin
               if (cnt == 2'd2) head <= tail;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  head <= wr_c;
               end else begin
                  head <= tail;
                  tail <= wr_c;
               end
            end
            default: ;
         endcase

         case (state)
            IDLE: begin
               if (start && (frame_len != '0)) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  idx      <= '0;
                  last_idx <= (frame_len > MAX_LEN) ? '1 : N_LOG2'(frame_len - 1'b1);
               end
            end
            RUN: begin
               if (rd_c) begin
                  idx <= idx + 1'b1;
                  if (final_rd_c) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pop_c && head.last) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_out_sequencer.sv
// Directed bench for fft_out_sequencer: three instances cover 8-point bit-reversed,
// 8-point natural order and 256-point bit-reversed configurations.
module tb_fft_out_sequencer;

   logic clk;
   logic rst_n;

   logic       start_a, start_b, start_c;
   logic [3:0] len_a, len_b;
   logic [8:0] len_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;

   fft_out_sequencer_if #(.N_LOG2(3), .DW(32)) if_a ();
   fft_out_sequencer_if #(.N_LOG2(3), .DW(32)) if_b ();
   fft_out_sequencer_if #(.N_LOG2(8), .DW(32)) if_c ();

   fft_out_sequencer #(.N_LOG2(3), .DW(32), .BITREV(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .frame_len(len_a),
      .busy(busy_a), .done(done_a), .bus(if_a)
   );
   fft_out_sequencer #(.N_LOG2(3), .DW(32), .BITREV(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .frame_len(len_b),
      .busy(busy_b), .done(done_b), .bus(if_b)
   );
   fft_out_sequencer #(.N_LOG2(8), .DW(32), .BITREV(1'b1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .frame_len(len_c),
      .busy(busy_c), .done(done_c), .bus(if_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM models with one cycle read latency, RAM[a] = a
   always @(posedge clk) begin
      if (if_a.rd_en) if_a.rd_data <= 32'(if_a.rd_addr);
      if (if_b.rd_en) if_b.rd_data <= 32'(if_b.rd_addr);
      if (if_c.rd_en) if_c.rd_data <= 32'(if_c.rd_addr);
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int          a_addr[$], b_addr[$], c_addr[$];
   logic [32:0] a_out[$], b_out[$], c_out[$];
   int a_done = 0, a_done_t = 0, a_first_t = 0, a_xfer_t = 0;
   int b_done = 0, b_done_t = 0, b_xfer_t = 0, b_start_t = 0;
   int b_busy_n = 0, b_busy_first = 0, b_busy_last = 0;
   int c_done = 0, c_outst = 0, c_ovf = 0, c_hold = 0, c_valid_n = 0, c_busy_n = 0;
   logic        c_stall = 1'b0;
   logic [31:0] c_stall_data = '0;

   // Transaction monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (if_a.rd_en) a_addr.push_back(int'(if_a.rd_addr));
      if (if_a.out_valid && if_a.out_ready) begin
         if (a_out.size() == 0) a_first_t = cyc;
         a_out.push_back({if_a.out_last, if_a.out_data});
         a_xfer_t = cyc;
      end
      if (done_a) begin a_done++; a_done_t = cyc; end

      if (if_b.rd_en) b_addr.push_back(int'(if_b.rd_addr));
      if (if_b.out_valid && if_b.out_ready) begin
         b_out.push_back({if_b.out_last, if_b.out_data});
         b_xfer_t = cyc;
      end
      if (start_b) b_start_t = cyc;
      if (busy_b) begin
         if (b_busy_n == 0) b_busy_first = cyc;
         b_busy_n++;
         b_busy_last = cyc;
      end
      if (done_b) begin b_done++; b_done_t = cyc; end

      if (!rst_n) c_outst = 0;
      if (if_c.rd_en) begin c_addr.push_back(int'(if_c.rd_addr)); c_outst++; end
      if (if_c.out_valid && if_c.out_ready) begin
         c_out.push_back({if_c.out_last, if_c.out_data});
         c_outst--;
      end
      if (c_outst > 2) c_ovf++;
      if (c_stall && rst_n && (!if_c.out_valid || if_c.out_data != c_stall_data)) c_hold++;
      c_stall      = if_c.out_valid && !if_c.out_ready && rst_n;
      c_stall_data = if_c.out_data;
      if (if_c.out_valid) c_valid_n++;
      if (busy_c) c_busy_n++;
      if (done_c) c_done++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int brev(input int v, input int n);
      int r = 0;
      for (int i = 0; i < n; i++) if (((v >> i) & 1) != 0) r |= (1 << (n - 1 - i));
      return r;
   endfunction

   function automatic int done_cnt(input int w);
      case (w)
         0:       return a_done;
         1:       return b_done;
         default: return c_done;
      endcase
   endfunction

   // Mismatches of a 256-point bit-reversed frame of n words starting at queue position base
   function automatic int c_bad(input int base, input int n);
      int bad = 0;
      for (int k = 0; k < n; k++) begin
         logic [32:0] e;
         e = {(k == n - 1), 32'(brev(k, 8))};
         if (base + k >= c_out.size()) bad++;
         else if (c_out[base + k] !== e) bad++;
         if (base + k >= c_addr.size()) bad++;
         else if (c_addr[base + k] != brev(k, 8)) bad++;
      end
      return bad;
   endfunction

   task automatic wait_done(input int w, input int budget, input bit tog, input string tag);
      int d0;
      int n;
      d0 = done_cnt(w);
      n  = 0;
      while (done_cnt(w) == d0 && n < budget) begin
         @(posedge clk);
         #1;
         if (tog) if_c.out_ready = ~if_c.out_ready;
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk(tag, 64'(done_cnt(w) - d0), 64'd1);
   endtask

   task automatic clear_c();
      c_addr.delete();
      c_out.delete();
      c_done = 0; c_ovf = 0; c_hold = 0; c_valid_n = 0; c_busy_n = 0;
   endtask

   initial begin
      int bad;
      logic [32:0] e;
      rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      len_a = '0; len_b = '0; len_c = '0;
      if_a.out_ready = 1'b1;
      if_b.out_ready = 1'b1;
      if_c.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ctl", 64'({if_c.rd_en, if_c.out_valid, if_c.out_last, busy_c, done_c}), 64'd0);
      chk("reset_data", 64'(if_c.out_data), 64'd0);
      chk("reset_addr", 64'(if_c.rd_addr), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // 8-point bit-reversed frame at full throughput
      #1 start_a = 1'b1; len_a = 4'd8;
      @(posedge clk);
      #1 start_a = 1'b0;
      chk("t1_rd_en_latency", 64'({if_a.rd_en, busy_a}), 64'h3);
      chk("t1_first_addr", 64'(if_a.rd_addr), 64'd0);
      wait_done(0, 60, 1'b0, "t1_done");
      chk("t1_reads", 64'(a_addr.size()), 64'd8);
      chk("t1_words", 64'(a_out.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         e = {(i == 7), 32'(brev(i, 3))};
         chk("t1_addr", (i < a_addr.size()) ? 64'(a_addr[i]) : 64'hdead, 64'(brev(i, 3)));
         chk("t1_word", (i < a_out.size()) ? 64'(a_out[i]) : 64'hdead, 64'(e));
      end
      chk("t1_back_to_back", 64'(a_xfer_t - a_first_t), 64'd7);
      chk("t1_done_after_last", 64'(a_done_t - a_xfer_t), 64'd1);

      // natural order, 5 words
      @(posedge clk);
      #1 start_b = 1'b1; len_b = 4'd5;
      @(posedge clk);
      #1 start_b = 1'b0;
      wait_done(1, 60, 1'b0, "t3_done");
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         e = {(i == 4), 32'(i)};
         if (i >= b_addr.size() || b_addr[i] != i) bad++;
         if (i >= b_out.size() || b_out[i] !== e) bad++;
      end
      chk("t3_sequence", 64'(bad), 64'd0);
      chk("t3_counts", 64'({16'(b_addr.size()), 16'(b_out.size())}), 64'h0005_0005);
      chk("t3_busy_rise", 64'(b_busy_first), 64'(b_start_t + 1));
      chk("t3_busy_fall", 64'(b_busy_last), 64'(b_done_t - 1));
      chk("t3_busy_contig", 64'(b_busy_n), 64'(b_busy_last - b_busy_first + 1));
      chk("t3_last_xfer", 64'(b_xfer_t), 64'(b_done_t - 1));

      // 256 words with out_ready toggling every cycle
      clear_c();
      @(posedge clk);
      #1 start_c = 1'b1; len_c = 9'd256;
      @(posedge clk);
      #1 start_c = 1'b0;
      wait_done(2, 2000, 1'b1, "t2_done");
      if_c.out_ready = 1'b1;
      chk("t2_words", 64'(c_out.size()), 64'd256);
      chk("t2_reads", 64'(c_addr.size()), 64'd256);
      chk("t2_order", 64'(c_bad(0, 256)), 64'd0);
      chk("t2_no_overrun", 64'(c_ovf), 64'd0);
      chk("t2_hold", 64'(c_hold), 64'd0);

      // zero length ignored, oversize length clamped
      clear_c();
      @(posedge clk);
      #1 start_c = 1'b1; len_c = 9'd0;
      @(posedge clk);
      #1 start_c = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("t4_len0_quiet", 64'({16'(c_busy_n), 16'(c_valid_n), 16'(c_done)}), 64'd0);
      #1 start_c = 1'b1; len_c = 9'd300;
      @(posedge clk);
      #1 start_c = 1'b0;
      wait_done(2, 1000, 1'b0, "t4_clamp_done");
      chk("t4_clamp_words", 64'(c_out.size()), 64'd256);
      chk("t4_clamp_order", 64'(c_bad(0, 256)), 64'd0);

      // start while busy ignored
      clear_c();
      @(posedge clk);
      #1 start_c = 1'b1; len_c = 9'd16;
      @(posedge clk);
      #1 start_c = 1'b0;
      repeat (5) @(posedge clk);
      #1 start_c = 1'b1; len_c = 9'd200;
      @(posedge clk);
      #1 start_c = 1'b0;
      wait_done(2, 200, 1'b0, "t5_busy_start_done");
      chk("t5_words", 64'(c_out.size()), 64'd16);
      chk("t5_order", 64'(c_bad(0, 16)), 64'd0);
      repeat (5) @(posedge clk);
      chk("t5_no_extra_frame", 64'({busy_c, 16'(c_done)}), 64'd1);

      // new start accepted in the done cycle
      clear_c();
      #1 start_c = 1'b1; len_c = 9'd4;
      @(posedge clk);
      #1 start_c = 1'b0;
      for (int n = 0; n < 100 && !done_c; n++) begin
         @(posedge clk);
         #1;
      end
      chk("t5_done_seen", 64'(done_c), 64'd1);
      chk("t5_busy_low_with_done", 64'(busy_c), 64'd0);
      start_c = 1'b1; len_c = 9'd3;
      @(posedge clk);
      #1 start_c = 1'b0;
      chk("t5_restart_busy", 64'({busy_c, if_c.rd_en}), 64'h3);
      wait_done(2, 100, 1'b0, "t5_restart_done");
      chk("t5_two_frames", 64'({16'(c_out.size()), 16'(c_done)}), 64'h0007_0002);
      chk("t5_frames_order", 64'(c_bad(0, 4) + c_bad(4, 3)), 64'd0);

      // asynchronous reset mid-frame with the consumer stalled
      clear_c();
      if_c.out_ready = 1'b0;
      @(posedge clk);
      #1 start_c = 1'b1; len_c = 9'd32;
      @(posedge clk);
      #1 start_c = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("t6_stalled_valid", 64'({if_c.out_valid, busy_c}), 64'h3);
      rst_n = 1'b0;
      #1;
      chk("t6_reset_ctl", 64'({if_c.rd_en, if_c.out_valid, if_c.out_last, busy_c, done_c}), 64'd0);
      chk("t6_reset_data", 64'({if_c.out_data, 8'(if_c.rd_addr)}), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("t6_no_done_on_abort", 64'(c_done), 64'd0);
      clear_c();
      if_c.out_ready = 1'b1;
      start_c = 1'b1; len_c = 9'd4;
      @(posedge clk);
      #1 start_c = 1'b0;
      wait_done(2, 100, 1'b0, "t6_fresh_done");
      chk("t6_fresh_words", 64'(c_out.size()), 64'd4);
      chk("t6_fresh_from_idx0", 64'(c_bad(0, 4)), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
